// File: rtl/spi_arbiter.sv
// Two-requester round-robin arbiter in front of a single SPI engine.
// One transaction in flight; WAIT aborts with rsp_err after TIMEOUT cycles.
module spi_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic       req1_valid,
    input  logic [7:0] req0_data,
    input  logic [7:0] req1_data,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic       rsp0_valid,
    output logic       rsp1_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       spi_start,
    output logic [7:0] spi_tx_data,
    input  logic       spi_done,
    input  logic       spi_busy,
    input  logic [7:0] spi_rx_data
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    localparam logic [15:0] CNT_MAX = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        gnt_q, gnt_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        pick;

    // On a tie the requester not granted last wins
    assign pick = (req0_valid && req1_valid) ? ~last_q : req1_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            tx_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            tx_q    <= tx_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        tx_d       = tx_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        spi_start  = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                // reset gates ready since it is combinational
                if ((req0_valid || req1_valid) && !spi_busy && reset) begin
                    req0_ready = ~pick;
                    req1_ready = pick;
                    gnt_d      = pick;
                    tx_d       = pick ? req1_data : req0_data;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                spi_start = 1'b1;
                cnt_d     = '0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (spi_done) begin
                    rdata_d = spi_rx_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_MAX) begin
                    rdata_d = 8'h00;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                rsp0_valid = ~gnt_q;
                rsp1_valid = gnt_q;
                last_d     = gnt_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign spi_tx_data = tx_q;
    assign rsp_data    = rdata_q;
    assign rsp_err     = err_q;

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 64, maximum cycles in WAIT before abort; legal range 2..65535.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: req0_valid / req1_valid  input  1  requester n has a byte to transfer.
REQ-005 Port: req0_data / req1_data  input  8  byte requester n sends to the slave.
REQ-006 Port: req0_ready / req1_ready  output  1  request accepted this cycle (combinational).
REQ-007 Port: rsp0_valid / rsp1_valid  output  1  one-cycle response pulse to requester n.
REQ-008 Port: rsp_data  output  8  byte received from the slave; shared by both requesters, valid with rsp_valid.
REQ-009 Port: rsp_err  output  1  timeout flag; valid with rsp_valid.
REQ-010 Port: spi_start  output  1  one-cycle start pulse to the SPI full-duplex engine.
REQ-011 Port: spi_tx_data  output  8  byte presented to the engine's master_data_in.
REQ-012 Port: spi_done  input  1  engine completion (engine done).
REQ-013 Port: spi_busy  input  1  engine busy (engine busy).
REQ-014 Port: spi_rx_data  input  8  engine master_data_out.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; encoding free.
REQ-016 IDLE: if any reqN_valid and spi_busy==0, SHALL grant one requester, assert its reqN_ready that cycle, latch reqN_data into spi_tx_data, record the grant, go to ISSUE.
REQ-017 IDLE with spi_busy==1 SHALL grant nothing; all reqN_ready SHALL be 0.
REQ-018 Arbitration SHALL be round-robin: on a tie, grant the requester not granted last; a single requester SHALL be granted regardless of history.
REQ-019 After reset the last-grant pointer SHALL be 1, so requester 0 wins the first tie.
REQ-020 reqN_ready SHALL be 0 in every state other than IDLE.
REQ-021 ISSUE: spi_start SHALL be 1 for exactly this one cycle; the timeout counter SHALL clear; next state SHALL be WAIT.
REQ-022 spi_tx_data SHALL hold the latched byte unchanged from ISSUE through RESP.
REQ-023 WAIT: spi_done==1 SHALL capture spi_rx_data into rsp_data, clear rsp_err and go to RESP.
REQ-024 WAIT: the counter SHALL increment each cycle without spi_done. When it reaches TIMEOUT-1 without spi_done, the block SHALL set rsp_err=1, set rsp_data=8'h00 and go to RESP.
REQ-025 If spi_done and the timeout occur in the same cycle, spi_done SHALL win (rsp_err=0).
REQ-026 spi_done SHALL be ignored outside WAIT.
REQ-027 RESP: rspN_valid SHALL be 1 for one cycle, on the granted requester only. The last-grant pointer SHALL update to that requester. Next state SHALL be IDLE.
REQ-028 Latency: accept at cycle T, spi_start at T+1, spi_done first seen at cycle D, rspN_valid at D+1; earliest next accept at D+2.
REQ-029 reqN_valid deasserting after acceptance SHALL have no effect on the in-flight transaction.
REQ-030 At most one transaction SHALL be outstanding; no request queueing.

Reset
REQ-031 While reset==0, state SHALL be IDLE and the counter 0.
REQ-032 While reset==0, all outputs SHALL be 0: spi_start, spi_tx_data=8'h00, rsp*_valid, rsp_data=8'h00, rsp_err, req*_ready.
REQ-033 While reset==0, the last-grant pointer SHALL be 1.
REQ-034 Reset assertion mid-transaction SHALL abort immediately with no response pulse; after release, the block SHALL behave as freshly reset.

Verification
REQ-035 Single request: req0 0xA5, slave-side 0x3C -> one spi_start with spi_tx_data 0xA5; rsp0_valid one cycle after spi_done with rsp_data 0x3C, rsp_err 0; rsp1_valid never high.
REQ-036 Simultaneous req0 0x55 and req1 0xF0 held valid -> order req0, req1, req0, req1 over four transactions; each rsp on the matching port.
REQ-037 Timeout: TIMEOUT=8, engine never raises spi_done -> rsp0_valid with rsp_err 1, rsp_data 0x00; the next request is served normally.
REQ-038 spi_done on the exact timeout cycle -> rsp_err 0, rsp_data = spi_rx_data.
REQ-039 Reset asserted during WAIT -> all outputs 0 immediately; no rsp pulse; after release, first tie goes to req0.
REQ-040 spi_busy high in IDLE with req0 valid -> no ready, no spi_start until spi_busy falls; then grant on the next IDLE cycle.
